insertion_sorter_p: RTL and testbench

- Parametrised successor of the single-channel 16-bit insertion-sort buffer.
- Stack-style buffer with configurable data width and depth, and run-time selectable ascending or descending stable sort.
- Adds explicit error and output-valid pulses and a correct full flag at exactly 2^AW entries.
- Sits in the algorithm-exercise RTL set as a command-driven sorting store beside the other toggle-command blocks.

---
 rtl/insertion_sorter_p.sv | 241 ++++++++++++++++++++++++
 tb/tb_insertion_sorter_p.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/insertion_sorter_p.sv
// insertion_sorter_p: command-driven stack buffer with an in-place, stable
// insertion sort (ascending or descending, chosen when the sort starts).
// Commands arrive as level toggles on clear/push/pop/sort. The priority is
// clear > push > pop > sort, and only one command is taken per cycle.
// Optional build macro SORTER_CYCLES_EN adds the sort_cycles output. That
// output holds the busy-cycle count of the most recent sort, saturating.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | waiting for a command
// ST_CLEAR   | dropping all entries (count -> 0)
// ST_PUSH    | writing din on top of the stack
// ST_POP     | reading the top entry into dout
// ST_J_INIT  | sort start: j = 1, latch sort order
// ST_J_JMP   | outer loop test, key = A[j]
// ST_I_INIT  | i = j - 1
// ST_I_JMP   | inner loop test: stop on wrap or ordered(A[i], key)
// ST_I_SHIFT | A[i+1] = A[i], i = i - 1
// ST_I_END   | A[i+1] = key
// ST_J_INC   | j = j + 1
// ST_DONE    | sort finished
module insertion_sorter_p #(
  parameter  int DW = 16,
  parameter  int AW = 8,
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          enable,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic          sort,
  input  logic          descend,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          dout_vld,
  output logic          err,
  output logic          full,
  output logic          empty,
  output logic          idle,
  output logic [CW-1:0] count
`ifdef SORTER_CYCLES_EN
  ,
  output logic [15:0]   sort_cycles
`endif
);

  localparam int            DEPTH    = 1 << AW;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef enum logic [3:0] {
    ST_IDLE    = 4'b0000,
    ST_CLEAR   = 4'b0001,
    ST_PUSH    = 4'b0011,
    ST_POP     = 4'b0010,
    ST_J_INIT  = 4'b0110,
    ST_J_JMP   = 4'b0111,
    ST_I_INIT  = 4'b0101,
    ST_I_JMP   = 4'b0100,
    ST_I_SHIFT = 4'b1100,
    ST_I_END   = 4'b1101,
    ST_J_INC   = 4'b1111,
    ST_DONE    = 4'b1110
  } state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] mem [DEPTH];

  logic          d_push, d_pop, d_clear, d_sort;
  logic          f_push, f_pop, f_clear, f_sort, any_fire;
  logic          reject;

  // j and i carry one extra bit: j can reach 2^AW and i can wrap below zero
  logic [CW-1:0] j, i;
  logic [DW-1:0] key;
  logic          desc_r;

  logic [CW-1:0] cnt_m1, count_nxt;
  logic [AW-1:0] i_p1;
  logic [DW-1:0] a_i;
  logic          i_wrap, in_order;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

  // A toggle in either direction fires. Nothing is consumed while enable is low.
  assign f_push   = enable & (push  ^ d_push);
  assign f_pop    = enable & (pop   ^ d_pop);
  assign f_clear  = enable & (clear ^ d_clear);
  assign f_sort   = enable & (sort  ^ d_sort);
  assign any_fire = f_push | f_pop | f_clear | f_sort;

  assign cnt_m1   = count - CW'(1);
  assign i_p1     = i[AW-1:0] + AW'(1);
  assign a_i      = mem[i[AW-1:0]];
  assign i_wrap   = &i;
  // Equal keys count as ordered, so they never move and the sort stays stable
  assign in_order = desc_r ? (a_i >= key) : (a_i <= key);

  // Command delay flops hold the last seen level of each toggle input
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      d_push  <= 1'b0;
      d_pop   <= 1'b0;
      d_clear <= 1'b0;
      d_sort  <= 1'b0;
    end else if (enable) begin
      d_push  <= push;
      d_pop   <= pop;
      d_clear <= clear;
      d_sort  <= sort;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else if (enable) state <= state_nxt;
  end

  // Next-state logic and command acceptance/rejection
  always_comb begin
    state_nxt = state;
    reject    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (f_clear) state_nxt = ST_CLEAR;
        else if (f_push) begin
          if (count == CNT_FULL) reject = 1'b1;
          else state_nxt = ST_PUSH;
        end else if (f_pop) begin
          if (count == '0) reject = 1'b1;
          else state_nxt = ST_POP;
        end else if (f_sort) state_nxt = ST_J_INIT;
      end
      ST_CLEAR, ST_PUSH, ST_POP: state_nxt = ST_IDLE;
      ST_J_INIT:  state_nxt = ST_J_JMP;
      ST_J_JMP:   state_nxt = (j >= count) ? ST_DONE : ST_I_INIT;
      ST_I_INIT:  state_nxt = ST_I_JMP;
      ST_I_JMP:   state_nxt = (i_wrap || in_order) ? ST_I_END : ST_I_SHIFT;
      ST_I_SHIFT: state_nxt = ST_I_JMP;
      ST_I_END:   state_nxt = ST_J_INC;
      ST_J_INC:   state_nxt = ST_J_JMP;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
    if (state != ST_IDLE) reject = any_fire;
  end

  // State-decoded memory write port and next occupancy
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = count[AW-1:0];
    mem_wdata = din;
    count_nxt = count;
    case (state)
      ST_CLEAR: count_nxt = '0;
      ST_PUSH: begin
        mem_we    = 1'b1;
        count_nxt = count + CW'(1);
      end
      ST_POP: count_nxt = cnt_m1;
      ST_I_SHIFT: begin
        mem_we    = 1'b1;
        mem_waddr = i_p1;
        mem_wdata = a_i;
      end
      ST_I_END: begin
        mem_we    = 1'b1;
        mem_waddr = i_p1;
        mem_wdata = key;
      end
      default: ;
    endcase
  end

  // Storage array; contents are not reset
  always_ff @(posedge clk) begin
    if (enable && mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Datapath registers, pulses and registered status flags
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count    <= '0;
      j        <= '0;
      i        <= '0;
      key      <= '0;
      desc_r   <= 1'b0;
      dout     <= '0;
      dout_vld <= 1'b0;
      err      <= 1'b0;
      full     <= 1'b0;
      empty    <= 1'b1;
      idle     <= 1'b1;
    end else if (enable) begin
      count    <= count_nxt;
      err      <= reject;
      dout_vld <= (state == ST_POP);
      full     <= (count_nxt == CNT_FULL);
      empty    <= (count_nxt == '0);
      idle     <= (state_nxt == ST_IDLE);
      case (state)
        ST_POP:     dout <= mem[cnt_m1[AW-1:0]];
        ST_J_INIT: begin
          j      <= CW'(1);
          desc_r <= descend;
        end
        // j may equal 2^AW here; the key is then unused, so the truncated index is harmless
        ST_J_JMP:   key <= mem[j[AW-1:0]];
        ST_I_INIT:  i <= j - CW'(1);
        ST_I_SHIFT: i <= i - CW'(1);
        ST_J_INC:   j <= j + CW'(1);
        default: ;
      endcase
    end
  end

`ifdef SORTER_CYCLES_EN
  logic [15:0] cyc_run;
  logic        in_sort;

  assign in_sort = !(state inside {ST_IDLE, ST_CLEAR, ST_PUSH, ST_POP});

  // Busy-cycle counter for the running sort, published when ST_DONE is left
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cyc_run     <= '0;
      sort_cycles <= '0;
    end else if (enable) begin
      if (state == ST_J_INIT) cyc_run <= 16'd1;
      else if (in_sort && cyc_run != 16'hFFFF) cyc_run <= cyc_run + 16'd1;
      if (state == ST_DONE)
        sort_cycles <= (cyc_run == 16'hFFFF) ? 16'hFFFF : cyc_run + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_insertion_sorter_p.sv
// Testbench for insertion_sorter_p (DW=16, AW=3). It uses a queue-based
// reference model of the stack contents. Sorted order comes from a whole-queue
// sort, and the sort duration comes from the inversion count.
module tb_insertion_sorter_p;
  localparam int DW    = 16;
  localparam int AW    = 3;
  localparam int CW    = AW + 1;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rstn, enable, push, pop, clear, sort, descend;
  logic [DW-1:0] din, dout;
  logic          dout_vld, err, full, empty, idle;
  logic [CW-1:0] count;
`ifdef SORTER_CYCLES_EN
  logic [15:0]   sort_cycles;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] model[$];

  insertion_sorter_p #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .push(push), .pop(pop),
    .clear(clear), .sort(sort), .descend(descend), .din(din), .dout(dout),
    .dout_vld(dout_vld), .err(err), .full(full), .empty(empty), .idle(idle),
    .count(count)
`ifdef SORTER_CYCLES_EN
    , .sort_cycles(sort_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // which: 0 clear, 1 push, 2 pop, 3 sort. Returns err after the firing edge and busy cycles.
  task automatic cmd(input int which, input logic [DW-1:0] v, output logic e, output int busy);
    din = v;
    case (which)
      0: clear = ~clear;
      1: push  = ~push;
      2: pop   = ~pop;
      default: sort = ~sort;
    endcase
    cyc();
    e    = err;
    busy = 0;
    while (!idle && busy < 2000) begin
      busy++;
      cyc();
    end
  endtask

  // Reference sort: stable order by value; insertion-sort shifts equal the strict inversions
  task automatic model_sort(input logic desc, output int exp_cyc);
    int inv = 0;
    int n = model.size();
    for (int p = 0; p < n; p++)
      for (int q = p + 1; q < n; q++)
        if (desc ? (model[p] < model[q]) : (model[p] > model[q])) inv++;
    if (desc) model.rsort();
    else model.sort();
    exp_cyc = (n < 2) ? 3 : 3 + 5 * (n - 1) + 2 * inv;
  endtask

  task automatic test_reset();
    rstn = 1'b0; enable = 1'b1; push = 1'b0; pop = 1'b0; clear = 1'b0; sort = 1'b0;
    descend = 1'b0; din = '0;
    repeat (3) cyc();
    rstn = 1'b1;
    repeat (5) cyc();
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b want 0", full); end
    n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL reset_idle: got %b want 1", idle); end
    n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (dout !== '0) begin n_bad++; $display("FAIL reset_dout: got %0h want 0", dout); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
    n_cmp++; if (dout_vld !== 1'b0) begin n_bad++; $display("FAIL reset_dout_vld: got %b want 0", dout_vld); end
    model.delete();
  endtask

  task automatic test_sort_example(input logic desc, input logic [DW-1:0] v0, v1, v2, v3);
    logic e;
    int busy, exp_cyc, pulses;
    logic [DW-1:0] vals[4];
    logic [DW-1:0] exp_v;
    vals[0] = v0; vals[1] = v1; vals[2] = v2; vals[3] = v3;
    for (int k = 0; k < 4; k++) begin
      cmd(1, vals[k], e, busy);
      model.push_back(vals[k]);
      n_cmp++; if (e !== 1'b0 || busy != 1) begin n_bad++; $display("FAIL ex_push: err %b busy %0d want 0/1", e, busy); end
    end
    descend = desc;
    model_sort(desc, exp_cyc);
    cmd(3, '0, e, busy);
    n_cmp++; if (busy != exp_cyc) begin n_bad++; $display("FAIL ex_sort_cycles: got %0d want %0d", busy, exp_cyc); end
    n_cmp++; if (count !== CW'(4)) begin n_bad++; $display("FAIL ex_sort_count: got %0d want 4", count); end
`ifdef SORTER_CYCLES_EN
    n_cmp++; if (sort_cycles !== 16'(exp_cyc)) begin n_bad++; $display("FAIL ex_sort_cycles_port: got %0d want %0d", sort_cycles, exp_cyc); end
`endif
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      cmd(2, '0, e, busy);
      exp_v = model.pop_back();
      if (dout_vld === 1'b1) pulses++;
      n_cmp++; if (dout !== exp_v) begin n_bad++; $display("FAIL ex_pop_data: got %0d want %0d", dout, exp_v); end
      cyc();
      n_cmp++; if (dout_vld !== 1'b0) begin n_bad++; $display("FAIL ex_vld_width: got %b want 0", dout_vld); end
    end
    n_cmp++; if (pulses != 4) begin n_bad++; $display("FAIL ex_vld_pulses: got %0d want 4", pulses); end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL ex_empty_end: got %b want 1", empty); end
  endtask

  task automatic test_full_boundary();
    logic e;
    int busy;
    logic [DW-1:0] dout_before;
    cmd(0, '0, e, busy);
    model.delete();
    for (int k = 0; k < DEPTH; k++) begin
      n_cmp++; if (full !== 1'b0) begin n_bad++; $display("FAIL full_early: got %b want 0 at %0d", full, k); end
      cmd(1, DW'(k + 100), e, busy);
    end
    n_cmp++; if (full !== 1'b1) begin n_bad++; $display("FAIL full_set: got %b want 1", full); end
    n_cmp++; if (count !== CW'(DEPTH)) begin n_bad++; $display("FAIL full_count: got %0d want %0d", count, DEPTH); end
    cmd(1, 16'h7777, e, busy);
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL push_full_err: got %b want 1", e); end
    n_cmp++; if (busy != 0) begin n_bad++; $display("FAIL push_full_busy: got %0d want 0", busy); end
    n_cmp++; if (count !== CW'(DEPTH)) begin n_bad++; $display("FAIL push_full_count: got %0d want %0d", count, DEPTH); end
    cyc();
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL err_width: got %b want 0", err); end
    cmd(0, '0, e, busy);
    n_cmp++; if (empty !== 1'b1 || full !== 1'b0) begin n_bad++; $display("FAIL clear_flags: empty %b full %b want 1/0", empty, full); end
    dout_before = dout;
    cmd(2, '0, e, busy);
    n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL pop_empty_err: got %b want 1", e); end
    n_cmp++; if (dout !== dout_before || dout_vld !== 1'b0) begin n_bad++; $display("FAIL pop_empty_dout: got %0h/%b want %0h/0", dout, dout_vld, dout_before); end
    cyc();
  endtask

  task automatic test_busy_reject();
    logic e;
    int busy, exp_cyc;
    logic [DW-1:0] v, exp_v, dout_before;
    cmd(0, '0, e, busy);
    model.delete();
    for (int k = 0; k < 5; k++) begin
      v = DW'($urandom_range(0, 15));
      cmd(1, v, e, busy);
      model.push_back(v);
    end
    descend = 1'($urandom_range(0, 1));
    model_sort(descend, exp_cyc);
    sort = ~sort;
    cyc();
    busy = 0;
    while (!idle && busy < 2000) begin
      busy++;
      if (busy == 3) begin din = 16'hBEEF; push = ~push; end
      if (busy == 4) begin
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL busy_push_err: got %b want 1", err); end
      end
      if (busy == 5) begin
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL busy_err_width: got %b want 0", err); end
      end
      cyc();
    end
    n_cmp++; if (busy != exp_cyc) begin n_bad++; $display("FAIL busy_sort_cycles: got %0d want %0d", busy, exp_cyc); end
    n_cmp++; if (count !== CW'(5)) begin n_bad++; $display("FAIL busy_count: got %0d want 5", count); end
    while (model.size() > 0) begin
      cmd(2, '0, e, busy);
      exp_v = model.pop_back();
      n_cmp++; if (dout !== exp_v) begin n_bad++; $display("FAIL busy_pop_data: got %0h want %0h", dout, exp_v); end
    end
    cmd(1, 16'h0011, e, busy);
    cmd(1, 16'h0022, e, busy);
    dout_before = dout;
    clear = ~clear;
    pop   = ~pop;
    cyc();
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL clear_pop_err: got %b want 0", err); end
    busy = 0;
    while (!idle && busy < 2000) begin busy++; cyc(); end
    n_cmp++; if (busy != 1 || count !== '0) begin n_bad++; $display("FAIL clear_pop_taken: busy %0d count %0d want 1/0", busy, count); end
    n_cmp++; if (dout_vld !== 1'b0 || dout !== dout_before) begin n_bad++; $display("FAIL clear_pop_dout: got %0h/%b want %0h/0", dout, dout_vld, dout_before); end
    model.delete();
  endtask

  task automatic test_reset_mid_sort();
    logic e;
    int busy;
    cmd(0, '0, e, busy);
    for (int k = 0; k < 4; k++) cmd(1, DW'(4 - k), e, busy);
    descend = 1'b0;
    sort = ~sort;
    cyc();
    repeat (4) cyc();
    #2;
    rstn = 1'b0; push = 1'b0; pop = 1'b0; clear = 1'b0; sort = 1'b0;
    #1;
    n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL async_idle: got %b want 1", idle); end
    n_cmp++; if (count !== '0) begin n_bad++; $display("FAIL async_count: got %0d want 0", count); end
    n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL async_empty: got %b want 1", empty); end
    repeat (2) cyc();
    rstn = 1'b1;
    repeat (3) cyc();
    n_cmp++; if (idle !== 1'b1 || count !== '0 || err !== 1'b0) begin n_bad++; $display("FAIL post_reset: idle %b count %0d err %b want 1/0/0", idle, count, err); end
    model.delete();
  endtask

  task automatic test_enable_hold();
    logic e;
    int busy;
    enable = 1'b0;
    din = 16'h0055;
    push = ~push;
    repeat (4) cyc();
    n_cmp++; if (count !== '0 || idle !== 1'b1 || err !== 1'b0) begin n_bad++; $display("FAIL en_hold: count %0d idle %b err %b want 0/1/0", count, idle, err); end
    enable = 1'b1;
    cyc();
    n_cmp++; if (idle !== 1'b0) begin n_bad++; $display("FAIL en_fire: idle %b want 0", idle); end
    cyc();
    n_cmp++; if (count !== CW'(1) || idle !== 1'b1) begin n_bad++; $display("FAIL en_push: count %0d idle %b want 1/1", count, idle); end
    repeat (3) cyc();
    n_cmp++; if (count !== CW'(1) || err !== 1'b0) begin n_bad++; $display("FAIL en_once: count %0d err %b want 1/0", count, err); end
    cmd(2, '0, e, busy);
    n_cmp++; if (dout !== 16'h0055) begin n_bad++; $display("FAIL en_pop_data: got %0h want 55", dout); end
  endtask

  task automatic test_random();
    logic e;
    int busy, exp_cyc, n;
    logic [DW-1:0] v, exp_v;
    for (int r = 0; r < 20; r++) begin
      cmd(0, '0, e, busy);
      model.delete();
      n_cmp++; if (e !== 1'b0 || count !== '0) begin n_bad++; $display("FAIL rnd_clear: err %b count %0d want 0/0", e, count); end
      n = $urandom_range(0, DEPTH);
      for (int k = 0; k < n; k++) begin
        v = (r % 2 == 1) ? DW'($urandom_range(0, 7)) : DW'($urandom());
        cmd(1, v, e, busy);
        model.push_back(v);
        n_cmp++; if (e !== 1'b0) begin n_bad++; $display("FAIL rnd_push_err: got %b want 0", e); end
      end
      if (n > 0 && $urandom_range(0, 1) == 1) begin
        cmd(2, '0, e, busy);
        exp_v = model.pop_back();
        n_cmp++; if (dout !== exp_v || dout_vld !== 1'b1) begin n_bad++; $display("FAIL rnd_pre_pop: got %0h/%b want %0h/1", dout, dout_vld, exp_v); end
      end
      descend = 1'($urandom_range(0, 1));
      model_sort(descend, exp_cyc);
      cmd(3, '0, e, busy);
      n_cmp++; if (busy != exp_cyc) begin n_bad++; $display("FAIL rnd_sort_cycles: got %0d want %0d", busy, exp_cyc); end
      n_cmp++; if (count !== CW'(model.size())) begin n_bad++; $display("FAIL rnd_sort_count: got %0d want %0d", count, model.size()); end
`ifdef SORTER_CYCLES_EN
      n_cmp++; if (sort_cycles !== 16'(exp_cyc)) begin n_bad++; $display("FAIL rnd_cycles_port: got %0d want %0d", sort_cycles, exp_cyc); end
`endif
      while (model.size() > 0) begin
        cmd(2, '0, e, busy);
        exp_v = model.pop_back();
        n_cmp++; if (dout !== exp_v || dout_vld !== 1'b1) begin n_bad++; $display("FAIL rnd_pop: got %0h/%b want %0h/1", dout, dout_vld, exp_v); end
      end
      n_cmp++; if (empty !== 1'b1) begin n_bad++; $display("FAIL rnd_empty: got %b want 1", empty); end
      cmd(2, '0, e, busy);
      n_cmp++; if (e !== 1'b1) begin n_bad++; $display("FAIL rnd_pop_empty_err: got %b want 1", e); end
      cyc();
    end
  endtask

  initial begin
    test_reset();
    test_sort_example(1'b0, 16'd3, 16'd1, 16'd2, 16'd1);
    test_sort_example(1'b1, 16'd1, 16'd2, 16'd3, 16'd4);
    test_full_boundary();
    test_busy_reject();
    test_reset_mid_sort();
    test_enable_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
